ecc_apb_sequencer: RTL and testbench

ECC_APB_SEQUENCER -- requirements
Module: ecc_apb_sequencer

---
 rtl/ecc_apb_sequencer_if.sv | 45 ++++
 rtl/ecc_apb_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ecc_apb_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_apb_sequencer_if.sv
// rtl/ecc_apb_sequencer_if.sv - command, APB master and result signal bundle for ecc_apb_sequencer
interface ecc_apb_sequencer_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int FIFO_DEPTH      = 4
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [1:0]                   cmd_ctrl;
    logic [1:0]                   cmd_width;
    logic [AMBA_WORD-1:0]         cmd_data;
    logic [AMBA_WORD-1:0]         cmd_noise;

    logic [AMBA_ADDR_WIDTH-1:0]   PADDR;
    logic [AMBA_WORD-1:0]         PWDATA;
    logic                         PSEL;
    logic                         PENABLE;
    logic                         PWRITE;

    logic                         operation_done;
    logic [DATA_WIDTH-1:0]        data_out;
    logic [1:0]                   num_of_errors;

    logic                         res_valid;
    logic [DATA_WIDTH-1:0]        res_data;
    logic [1:0]                   res_num_of_errors;
    logic                         res_timeout;
    logic                         busy;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    modport master (
        input  cmd_valid, cmd_ctrl, cmd_width, cmd_data, cmd_noise,
        input  operation_done, data_out, num_of_errors,
        output cmd_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        output res_valid, res_data, res_num_of_errors, res_timeout, busy, fifo_count
    );

    modport slave (
        output cmd_valid, cmd_ctrl, cmd_width, cmd_data, cmd_noise,
        output operation_done, data_out, num_of_errors,
        input  cmd_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        input  res_valid, res_data, res_num_of_errors, res_timeout, busy, fifo_count
    );
endinterface

// File: rtl/ecc_apb_sequencer.sv
// rtl/ecc_apb_sequencer.sv - queues ECC commands and replays each as four APB register writes, then collects the result
module ecc_apb_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic clk,
    input  logic rst,
    ecc_apb_sequencer_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMAX_C  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WAIT_DONE,
        S_REPORT
    } state_t;

    logic [1:0]           r_q_ctrl  [FIFO_DEPTH];
    logic [1:0]           r_q_width [FIFO_DEPTH];
    logic [AMBA_WORD-1:0] r_q_data  [FIFO_DEPTH];
    logic [AMBA_WORD-1:0] r_q_noise [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    state_t                     r_state;
    logic [1:0]                 r_idx;
    logic [TW-1:0]              r_timer;
    logic [1:0]                 r_w_ctrl;
    logic [1:0]                 r_w_width;
    logic [AMBA_WORD-1:0]       r_w_noise;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic                       r_psel;
    logic                       r_penable;
    logic                       r_pwrite;
    logic                       r_res_valid;
    logic [DATA_WIDTH-1:0]      r_res_data;
    logic [1:0]                 r_res_nerr;
    logic                       r_res_timeout;

    logic                 w_cmd_ready;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_next_idx;
    logic [AMBA_WORD-1:0] w_next_pwdata;

    // Readiness comes only from the registered count, so a full FIFO drops a push even when popping.
    assign w_cmd_ready = (r_count < DEPTH_C);
    assign w_push      = bus.cmd_valid && w_cmd_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_next_idx  = r_idx + 2'd1;

    function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return BASE_ADDR + AMBA_ADDR_WIDTH'(4);
            2'd1:    return BASE_ADDR + AMBA_ADDR_WIDTH'(8);
            2'd2:    return BASE_ADDR + AMBA_ADDR_WIDTH'(12);
            default: return BASE_ADDR;
        endcase
    endfunction

    always_comb begin
        w_next_pwdata = '0;
        case (w_next_idx)
            2'd1:    w_next_pwdata = AMBA_WORD'(r_w_width);
            2'd2:    w_next_pwdata = r_w_noise;
            2'd3:    w_next_pwdata = AMBA_WORD'(r_w_ctrl);
            default: w_next_pwdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_ctrl[r_wr_ptr]  <= bus.cmd_ctrl;
            r_q_width[r_wr_ptr] <= bus.cmd_width;
            r_q_data[r_wr_ptr]  <= bus.cmd_data;
            r_q_noise[r_wr_ptr] <= bus.cmd_noise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_timer       <= '0;
            r_w_ctrl      <= '0;
            r_w_width     <= '0;
            r_w_noise     <= '0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_nerr    <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_w_ctrl  <= r_q_ctrl[r_rd_ptr];
                        r_w_width <= r_q_width[r_rd_ptr];
                        r_w_noise <= r_q_noise[r_rd_ptr];
                        r_idx     <= '0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b1;
                        r_paddr   <= reg_addr(2'd0);
                        r_pwdata  <= r_q_data[r_rd_ptr];
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (r_idx != 2'd3) begin
                        r_idx     <= w_next_idx;
                        r_penable <= 1'b0;
                        r_paddr   <= reg_addr(w_next_idx);
                        r_pwdata  <= w_next_pwdata;
                        r_state   <= S_SETUP;
                    end else begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_paddr   <= '0;
                        r_pwdata  <= '0;
                        r_timer   <= '0;
                        r_state   <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // A done arriving on the timeout edge still wins.
                    if (bus.operation_done) begin
                        r_res_data    <= bus.data_out;
                        r_res_nerr    <= bus.num_of_errors;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_REPORT;
                    end else if (r_timer == TMAX_C) begin
                        r_res_data    <= '0;
                        r_res_nerr    <= '0;
                        r_res_timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_REPORT;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_REPORT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready         = w_cmd_ready;
    assign bus.PADDR             = r_paddr;
    assign bus.PWDATA            = r_pwdata;
    assign bus.PSEL              = r_psel;
    assign bus.PENABLE           = r_penable;
    assign bus.PWRITE            = r_pwrite;
    assign bus.res_valid         = r_res_valid;
    assign bus.res_data          = r_res_data;
    assign bus.res_num_of_errors = r_res_nerr;
    assign bus.res_timeout       = r_res_timeout;
    assign bus.busy              = (r_state != S_IDLE);
    assign bus.fifo_count        = r_count;
endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb/tb_ecc_apb_sequencer.sv - directed self-checking bench for ecc_apb_sequencer
module tb_ecc_apb_sequencer;
    localparam int DW = 32, AW = 20, WD = 32, FD = 4, TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ecc_apb_sequencer_if #(.DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WD), .FIFO_DEPTH(FD)) bus ();

    ecc_apb_sequencer #(
        .DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WD),
        .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO), .BASE_ADDR(20'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct { logic [31:0] data; logic [1:0] nerr; logic to; } exp_t;
    typedef struct { logic [19:0] a; logic [31:0] d; } apb_t;

    exp_t sb[$];
    apb_t apb_log[$];
    int errors = 0, checks = 0;
    int cyc = 0, n_results = 0, cyc_res = 0, cyc_ctrl = 0, cyc_setup0 = 0;
    int resp_delay = 3, inject_req = 0, inject_ack = 0;
    logic resp_on = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and result scoreboard.
    logic        prev_setup = 1'b0, prev_rv = 1'b0;
    logic [19:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    apb_t        mon_a;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (rst) begin
            prev_setup = 1'b0;
            prev_rv    = 1'b0;
        end else begin
            if (bus.PSEL) begin
                check("pwrite", bus.PWRITE, 1);
                if (bus.PENABLE) begin
                    check("setup_before_access", prev_setup, 1);
                    check("access_addr_stable", bus.PADDR, prev_addr);
                    check("access_data_stable", bus.PWDATA, prev_data);
                    mon_a.a = bus.PADDR;
                    mon_a.d = bus.PWDATA;
                    apb_log.push_back(mon_a);
                    if (bus.PADDR == 20'h0) cyc_ctrl = cyc;
                end else if (bus.PADDR == 20'h4) begin
                    cyc_setup0 = cyc;
                end
            end else begin
                check("apb_idle_zero", {bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
            end
            prev_setup = bus.PSEL && !bus.PENABLE;
            prev_addr  = bus.PADDR;
            prev_data  = bus.PWDATA;
            if (bus.res_valid) begin
                n_results++;
                cyc_res = cyc;
                check("res_valid_pulse", prev_rv, 0);
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("res_data", bus.res_data, mon_e.data);
                    check("res_nerr", bus.res_num_of_errors, mon_e.nerr);
                    check("res_timeout", bus.res_timeout, mon_e.to);
                end
            end
            prev_rv = bus.res_valid;
        end
    end

    // DUT model: returns DATA_IN ^ 0xFF and NOISE[1:0] some cycles after the CTRL write.
    int          cnt = 0;
    logic [31:0] cap_data = '0, cap_noise = '0;
    always @(negedge clk) begin
        bus.operation_done = 1'b0;
        if (rst) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.operation_done = 1'b1;
                    bus.data_out       = cap_data ^ 32'hFF;
                    bus.num_of_errors  = cap_noise[1:0];
                end
            end
            if (bus.PSEL && bus.PENABLE) begin
                if (bus.PADDR == 20'h4) cap_data = bus.PWDATA;
                if (bus.PADDR == 20'hC) begin
                    cap_noise = bus.PWDATA;
                    if (inject_req != inject_ack) begin
                        bus.operation_done = 1'b1;
                        bus.data_out       = 32'hDEAD;
                        bus.num_of_errors  = 2'd3;
                        inject_ack++;
                    end
                end
                if (bus.PADDR == 20'h0 && resp_on) cnt = resp_delay;
            end
        end
    end

    task automatic push(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d,
                        input logic [31:0] n, input logic exp_to, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ctrl  = c;
        bus.cmd_width = w;
        bus.cmd_data  = d;
        bus.cmd_noise = n;
        acc = bus.cmd_ready;
        if (acc) begin
            e.data = exp_to ? 32'h0 : (d ^ 32'hFF);
            e.nerr = exp_to ? 2'd0 : n[1:0];
            e.to   = exp_to;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input int n, input int limit, input string tag);
        int k = 0;
        while (n_results < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        check(tag, n_results >= n, 1);
    endtask

    initial begin
        logic acc;
        int r, nr, k;
        logic found;
        bus.cmd_valid      = 1'b0;
        bus.cmd_ctrl       = '0;
        bus.cmd_width      = '0;
        bus.cmd_data       = '0;
        bus.cmd_noise      = '0;
        bus.operation_done = 1'b0;
        bus.data_out       = '0;
        bus.num_of_errors  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_apb", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res", {bus.res_data, bus.res_num_of_errors, bus.res_timeout}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single encode command and its register write sequence.
        push(2'd0, 2'd2, 32'hA5, 32'h0, 1'b0, acc);
        check("cmd1_accepted", acc, 1);
        idle();
        wait_res(1, 40, "cmd1_result_wait");
        check("cmd1_apb_len", apb_log.size(), 4);
        if (apb_log.size() == 4) begin
            check("cmd1_w0", {apb_log[0].a, apb_log[0].d}, {20'h4, 32'hA5});
            check("cmd1_w1", {apb_log[1].a, apb_log[1].d}, {20'h8, 32'h2});
            check("cmd1_w2", {apb_log[2].a, apb_log[2].d}, {20'hC, 32'h0});
            check("cmd1_w3", {apb_log[3].a, apb_log[3].d}, {20'h0, 32'h0});
        end
        check("cmd1_latency", cyc_res - cyc_ctrl, 4);

        // Immediate done: result two cycles after the CTRL access.
        resp_delay = 1;
        apb_log.delete();
        push(2'd2, 2'd1, 32'h1234, 32'h1, 1'b0, acc);
        idle();
        wait_res(2, 40, "cmd2_result_wait");
        check("cmd2_latency", cyc_res - cyc_ctrl, 2);
        if (apb_log.size() == 4) begin
            check("cmd2_width_wdata", apb_log[1].d, 32'h1);
            check("cmd2_ctrl_wdata", apb_log[3].d, 32'h2);
        end

        // Decode reporting two errors.
        push(2'd1, 2'd2, 32'h0F0F_0000, 32'h2, 1'b0, acc);
        idle();
        wait_res(3, 40, "cmd3_result_wait");

        // Fill the FIFO while the FSM is busy.
        resp_delay = 3;
        push(2'd0, 2'd0, 32'h100, 32'h0, 1'b0, acc);
        idle();
        for (int i = 0; i < 5; i++) begin
            push(2'd0, 2'd1, 32'h200 + i, 32'(i % 4), 1'b0, acc);
            check($sformatf("burst_accept_%0d", i), acc, (i < 4) ? 1 : 0);
        end
        idle();
        check("burst_fifo_full", bus.fifo_count, 4);
        check("burst_ready_low", bus.cmd_ready, 0);
        wait_res(4, 60, "burst_first_wait");
        r = cyc_res;
        repeat (3) @(posedge clk);
        check("next_pop_latency", cyc_setup0 - r, 2);
        wait_res(8, 300, "burst_all_wait");

        // Timeout path.
        resp_on = 1'b0;
        push(2'd0, 2'd0, 32'h77, 32'h0, 1'b1, acc);
        idle();
        wait_res(9, 60, "timeout_wait");
        check("timeout_latency", cyc_res - cyc_ctrl, 9);
        resp_on = 1'b1;

        // A done pulse during the NOISE access must be ignored.
        inject_req++;
        push(2'd0, 2'd3, 32'h3C, 32'h1, 1'b0, acc);
        idle();
        wait_res(10, 60, "glitch_wait");
        check("glitch_injected", inject_ack, inject_req);

        // Reset in the middle of a transfer with two commands queued.
        resp_on = 1'b0;
        for (int i = 0; i < 3; i++) push(2'd0, 2'd0, 32'h900 + i, 32'h0, 1'b1, acc);
        idle();
        found = 1'b0;
        k = 0;
        while (!found && k < 60) begin
            @(negedge clk);
            k++;
            if (bus.PSEL && !bus.PENABLE && bus.PADDR == 20'h0) found = 1'b1;
        end
        check("rst_ctrl_setup_found", found, 1);
        check("rst_queued_two", bus.fifo_count, 2);
        nr = n_results;
        rst = 1'b1;
        #1;
        check("midrst_apb", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
        check("midrst_fifo_count", bus.fifo_count, 0);
        check("midrst_busy", bus.busy, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", bus.cmd_ready, 1);
        repeat (30) @(posedge clk);
        check("midrst_no_result", n_results, nr);
        resp_on = 1'b1;

        // Recovery after reset.
        push(2'd1, 2'd2, 32'hCAFE_0001, 32'h3, 1'b0, acc);
        idle();
        wait_res(nr + 1, 40, "recover_wait");
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1);
    end
endmodule
